// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcode encodings and the opcode
// loaded when the stage holds a bubble.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'b0000,
        ALU_OP_SLL  = 4'b0001,
        ALU_OP_SLT  = 4'b0010,
        ALU_OP_SLTU = 4'b0011,
        ALU_OP_XOR  = 4'b0100,
        ALU_OP_SRL  = 4'b0101,
        ALU_OP_OR   = 4'b0110,
        ALU_OP_AND  = 4'b0111,
        ALU_OP_SUB  = 4'b1000,
        ALU_OP_EQ   = 4'b1001,
        ALU_OP_NEQ  = 4'b1010,
        ALU_OP_GE   = 4'b1100,
        ALU_OP_SRA  = 4'b1101,
        ALU_OP_GEU  = 4'b1111
    } alu_op_e;

    localparam logic [3:0] BUBBLE_ALU_OP = ALU_OP_ADD;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one source register: EX/MEM beats MEM/WB,
// which beats the latched register data. x0 is never forwarded.
module id_ex_stage_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [REG_AW-1:0] ex_mem_rd_i,
    input  logic              ex_mem_wr_i,
    input  logic [DATA_W-1:0] ex_mem_result_i,
    input  logic [REG_AW-1:0] mem_wb_rd_i,
    input  logic              mem_wb_wr_i,
    input  logic [DATA_W-1:0] mem_wb_result_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = ex_mem_wr_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs_addr_i);
    assign mem_wb_hit = mem_wb_wr_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == rs_addr_i);

    always_comb begin
        fwd_data_o = rs_data_i;
        if (ex_mem_hit) begin
            fwd_data_o = ex_mem_result_i;
        end else if (mem_wb_hit) begin
            fwd_data_o = mem_wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded fields, forwards
// from EX/MEM and MEM/WB, selects operands and detects load-use hazards.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic              id_op1_pc_i,
    input  logic              id_op2_imm_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] ex_mem_rd_i,
    input  logic              ex_mem_wr_i,
    input  logic [DATA_W-1:0] ex_mem_result_i,
    input  logic [REG_AW-1:0] mem_wb_rd_i,
    input  logic              mem_wb_wr_i,
    input  logic [DATA_W-1:0] mem_wb_result_i,
    output logic              hazard_o,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [3:0]        alu_op_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o
);

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [REG_AW-1:0] rs1_q,       rs1_d;
    logic [REG_AW-1:0] rs2_q,       rs2_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [3:0]        alu_op_q,    alu_op_d;
    logic              op1_pc_q,    op1_pc_d;
    logic              op2_imm_q,   op2_imm_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              wt_rs1;
    logic              wt_rs2;
    logic              load_use;
    logic [DATA_W-1:0] fwd_rs1;
    logic [DATA_W-1:0] fwd_rs2;

    // Load in the stage whose destination decode is about to read.
    assign load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
                      ((id_rs1_used_i && (id_rs1_i == rd_q)) ||
                       (id_rs2_used_i && (id_rs2_i == rd_q)));
    assign hazard_o = load_use && !flush_i && !stall_i;

    // A write-back landing this cycle is not yet visible in the register file.
    assign wt_rs1 = mem_wb_wr_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == id_rs1_i);
    assign wt_rs2 = mem_wb_wr_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == id_rs2_i);

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        alu_op_d    = alu_op_q;
        op1_pc_d    = op1_pc_q;
        op2_imm_d   = op2_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush_i || (!stall_i && hazard_o)) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            alu_op_d    = BUBBLE_ALU_OP;
            op1_pc_d    = 1'b0;
            op2_imm_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!stall_i) begin
            valid_d     = id_valid_i;
            pc_d        = id_pc_i;
            rs1_data_d  = wt_rs1 ? mem_wb_result_i : id_rs1_data_i;
            rs2_data_d  = wt_rs2 ? mem_wb_result_i : id_rs2_data_i;
            imm_d       = id_imm_i;
            rs1_d       = id_rs1_i;
            rs2_d       = id_rs2_i;
            rd_d        = id_rd_i;
            alu_op_d    = id_alu_op_i;
            op1_pc_d    = id_op1_pc_i;
            op2_imm_d   = id_op2_imm_i;
            reg_write_d = id_reg_write_i;
            mem_read_d  = id_mem_read_i;
            mem_write_d = id_mem_write_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_op_q    <= BUBBLE_ALU_OP;
            op1_pc_q    <= 1'b0;
            op2_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_op_q    <= alu_op_d;
            op1_pc_q    <= op1_pc_d;
            op2_imm_q   <= op2_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr_i       (rs1_q),
        .rs_data_i       (rs1_data_q),
        .ex_mem_rd_i     (ex_mem_rd_i),
        .ex_mem_wr_i     (ex_mem_wr_i),
        .ex_mem_result_i (ex_mem_result_i),
        .mem_wb_rd_i     (mem_wb_rd_i),
        .mem_wb_wr_i     (mem_wb_wr_i),
        .mem_wb_result_i (mem_wb_result_i),
        .fwd_data_o      (fwd_rs1)
    );

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr_i       (rs2_q),
        .rs_data_i       (rs2_data_q),
        .ex_mem_rd_i     (ex_mem_rd_i),
        .ex_mem_wr_i     (ex_mem_wr_i),
        .ex_mem_result_i (ex_mem_result_i),
        .mem_wb_rd_i     (mem_wb_rd_i),
        .mem_wb_wr_i     (mem_wb_wr_i),
        .mem_wb_result_i (mem_wb_result_i),
        .fwd_data_o      (fwd_rs2)
    );

    assign alu_data1_o    = op1_pc_q  ? pc_q  : fwd_rs1;
    assign alu_data2_o    = op2_imm_q ? imm_q : fwd_rs2;
    assign store_data_o   = fwd_rs2;
    assign alu_op_o       = alu_op_q;
    assign ex_valid_o     = valid_q;
    assign ex_pc_o        = pc_q;
    assign ex_rd_o        = rd_q;
    assign ex_reg_write_o = reg_write_q;
    assign ex_mem_read_o  = mem_read_q;
    assign ex_mem_write_o = mem_write_q;

endmodule
